// File: rtl/lbdr_input_fifo.sv
// Per-port FWFT flit buffer feeding LBDR routing; returns one credit per popped flit.
// Optional `FIFO_PROTO_CHECK_EN adds a sticky proto_err framing-violation flag.

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module lbdr_input_fifo #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned CREDIT_INIT = DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] flit_in,
    output logic                  credit_out,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] flit_out,
    output logic [2:0]            flit_id,
    output logic [3:0]            dst_addr,
    output logic                  empty,
    output logic                  full,
    output logic                  in_packet,
    output logic                  ovf_err
`ifdef FIFO_PROTO_CHECK_EN
    ,
    output logic                  proto_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lbdr_input_fifo: DEPTH must be a power of two >= 2");
    end
    if (CREDIT_INIT != DEPTH) begin : g_bad_credit
        $error("lbdr_input_fifo: CREDIT_INIT must equal DEPTH");
    end
    if (DATA_WIDTH < 32) begin : g_bad_width
        $error("lbdr_input_fifo: DATA_WIDTH must be at least 32");
    end

    typedef enum logic {StIdle, StPkt} pkt_state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [2:0]            in_id;
    pkt_state_e            state;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // Full is judged on the pre-read state, so a read never makes room for a same-cycle write.
    assign wr_fire = valid_in && !full;
    assign rd_fire = rd_en && !empty;
    assign in_id   = flit_in[31:29];

    assign flit_out = mem[rd_ptr[AW-1:0]];
    assign flit_id  = flit_out[31:29];
    assign dst_addr = flit_out[3:0];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= flit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            credit_out <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            credit_out <= rd_fire;
            if (valid_in && full) begin
                ovf_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            in_packet <= 1'b0;
        end else if (wr_fire) begin
            unique case (state)
                StIdle: begin
                    if (in_id == `HEADER) begin
                        state     <= StPkt;
                        in_packet <= 1'b1;
                    end
                end
                StPkt: begin
                    if (in_id == `TAIL) begin
                        state     <= StIdle;
                        in_packet <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    in_packet <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_PROTO_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (wr_fire) begin
            if ((state == StIdle && (in_id == `PAYLOAD || in_id == `TAIL)) ||
                (state == StPkt && in_id == `HEADER)) begin
                proto_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lbdr_input_fifo.sv
// Bench for lbdr_input_fifo: directed vector table, hand sequences, and randomized traffic
// checked against a queue-based reference model.

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module tb_lbdr_input_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_in = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] flit_in = '0;
    logic          credit_out;
    logic [DW-1:0] flit_out;
    logic [2:0]    flit_id;
    logic [3:0]    dst_addr;
    logic          empty;
    logic          full;
    logic          in_packet;
    logic          ovf_err;
`ifdef FIFO_PROTO_CHECK_EN
    logic          proto_err;
`endif

    lbdr_input_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CREDIT_INIT(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .flit_in   (flit_in),
        .credit_out(credit_out),
        .rd_en     (rd_en),
        .flit_out  (flit_out),
        .flit_id   (flit_id),
        .dst_addr  (dst_addr),
        .empty     (empty),
        .full      (full),
        .in_packet (in_packet),
        .ovf_err   (ovf_err)
`ifdef FIFO_PROTO_CHECK_EN
        ,
        .proto_err (proto_err)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] id, input logic [3:0] d,
                                       input int unsigned tag);
        logic [24:0] mid;
        mid = tag[24:0];
        return {id, mid, d};
    endfunction

    // Reference model: plain queue plus framing/sticky flags.
    logic [31:0] mq[$];
    bit m_credit, m_ovf, m_pkt, m_proto;

    task automatic step(input bit r, input bit v, input bit rd, input logic [31:0] f);
        bit was_full, was_empty, acc;
        logic [2:0] id;
        rst = r; valid_in = v; rd_en = rd; flit_in = f;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_credit = 0; m_ovf = 0; m_pkt = 0; m_proto = 0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            m_credit  = rd && !was_empty;
            acc       = v && !was_full;
            if (v && was_full) m_ovf = 1;
            if (m_credit) void'(mq.pop_front());
            if (acc) begin
                id = f[31:29];
                if (!m_pkt && (id == `PAYLOAD || id == `TAIL)) m_proto = 1;
                if (m_pkt && id == `HEADER) m_proto = 1;
                if (!m_pkt && id == `HEADER) m_pkt = 1;
                else if (m_pkt && id == `TAIL) m_pkt = 0;
                mq.push_back(f);
            end
        end
        #1;
        check("m_empty", 32'(empty), 32'(mq.size() == 0));
        check("m_full", 32'(full), 32'(mq.size() == DEPTH));
        check("m_credit", 32'(credit_out), 32'(m_credit));
        check("m_ovf", 32'(ovf_err), 32'(m_ovf));
        check("m_in_packet", 32'(in_packet), 32'(m_pkt));
`ifdef FIFO_PROTO_CHECK_EN
        check("m_proto", 32'(proto_err), 32'(m_proto));
`endif
        if (mq.size() != 0) begin
            check("m_flit_out", flit_out, mq[0]);
            check("m_flit_id", 32'(flit_id), 32'(mq[0][31:29]));
            check("m_dst_addr", 32'(dst_addr), 32'(mq[0][3:0]));
        end
    endtask

    typedef struct {
        bit          r, v, rd;
        logic [31:0] f;
        bit          e_empty, e_full, e_cr, e_pkt, e_ovf;
        logic [31:0] e_head;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit v, input bit rd, input logic [31:0] f,
                       input bit ee, input bit ef, input bit ec, input bit ep, input bit eo,
                       input logic [31:0] eh);
        vec_t x;
        x.r = r; x.v = v; x.rd = rd; x.f = f;
        x.e_empty = ee; x.e_full = ef; x.e_cr = ec; x.e_pkt = ep; x.e_ovf = eo; x.e_head = eh;
        tbl.push_back(x);
    endtask

    initial begin
        logic [31:0] h_a, p1, p2, t3, h5, h3, t7, h1, pa, pb, h9, q1, q2, q3, q4, h6, f;
        logic [2:0] rid;
        int credits;

        h_a = mk(`HEADER, 4'hA, 1);  p1 = mk(`PAYLOAD, 4'h0, 2);
        p2  = mk(`PAYLOAD, 4'h1, 3); t3 = mk(`TAIL, 4'h2, 4);
        h5  = mk(`HEADER, 4'h5, 5);  h3 = mk(`HEADER, 4'h3, 6);
        t7  = mk(`TAIL, 4'h7, 7);    h1 = mk(`HEADER, 4'h1, 8);
        pa  = mk(`PAYLOAD, 4'hB, 9); pb = mk(`PAYLOAD, 4'hC, 10);
        h9  = mk(`HEADER, 4'h9, 11); q1 = mk(`PAYLOAD, 4'h4, 12);
        q2  = mk(`PAYLOAD, 4'h6, 13); q3 = mk(`PAYLOAD, 4'h8, 14);
        q4  = mk(`TAIL, 4'hD, 15);   h6 = mk(`HEADER, 4'h6, 16);

        //  r  v rd flit  emp ful cr pkt ovf head
        add(1, 0, 0, '0,  1, 0, 0, 0, 0, '0);
        add(0, 1, 0, h_a, 0, 0, 0, 1, 0, h_a);
        add(0, 0, 0, '0,  0, 0, 0, 1, 0, h_a);
        add(0, 1, 0, p1,  0, 0, 0, 1, 0, h_a);
        add(0, 1, 0, p2,  0, 0, 0, 1, 0, h_a);
        add(0, 1, 0, t3,  0, 1, 0, 0, 0, h_a);
        add(0, 1, 0, h5,  0, 1, 0, 0, 1, h_a);
        add(0, 0, 1, '0,  0, 0, 1, 0, 1, p1);
        add(0, 0, 1, '0,  0, 0, 1, 0, 1, p2);
        add(0, 0, 1, '0,  0, 0, 1, 0, 1, t3);
        add(0, 0, 1, '0,  1, 0, 1, 0, 1, '0);
        add(0, 0, 1, '0,  1, 0, 0, 0, 1, '0);
        add(0, 0, 1, '0,  1, 0, 0, 0, 1, '0);
        add(0, 1, 1, h3,  0, 0, 0, 1, 1, h3);
        add(0, 1, 0, t7,  0, 0, 0, 0, 1, h3);
        add(0, 0, 1, '0,  0, 0, 1, 0, 1, t7);
        add(0, 0, 1, '0,  1, 0, 1, 0, 1, '0);
        add(0, 0, 0, '0,  1, 0, 0, 0, 1, '0);
        add(0, 1, 0, h1,  0, 0, 0, 1, 1, h1);
        add(0, 1, 0, pa,  0, 0, 0, 1, 1, h1);
        add(0, 1, 0, pb,  0, 0, 0, 1, 1, h1);
        add(1, 0, 0, '0,  1, 0, 0, 0, 0, '0);
        add(0, 1, 0, h9,  0, 0, 0, 1, 0, h9);
        add(0, 0, 1, '0,  1, 0, 1, 1, 0, '0);
        add(0, 1, 0, q1,  0, 0, 0, 1, 0, q1);
        add(0, 1, 0, q2,  0, 0, 0, 1, 0, q1);
        add(0, 1, 0, q3,  0, 0, 0, 1, 0, q1);
        add(0, 1, 0, q4,  0, 1, 0, 0, 0, q1);
        add(0, 1, 1, h6,  0, 0, 1, 0, 1, q2);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; valid_in = tbl[i].v; rd_en = tbl[i].rd; flit_in = tbl[i].f;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(tbl[i].e_full));
            check($sformatf("vec%0d_credit", i), 32'(credit_out), 32'(tbl[i].e_cr));
            check($sformatf("vec%0d_in_packet", i), 32'(in_packet), 32'(tbl[i].e_pkt));
            check($sformatf("vec%0d_ovf", i), 32'(ovf_err), 32'(tbl[i].e_ovf));
            if (!tbl[i].e_empty) begin
                check($sformatf("vec%0d_head", i), flit_out, tbl[i].e_head);
                check($sformatf("vec%0d_id", i), 32'(flit_id), 32'(tbl[i].e_head[31:29]));
                check($sformatf("vec%0d_dst", i), 32'(dst_addr), 32'(tbl[i].e_head[3:0]));
            end
        end

        // Steady stream from one entry: occupancy fixed, one credit per pop.
        step(1, 0, 0, '0);
        step(0, 1, 0, mk(`HEADER, 4'h2, 100));
        credits = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, mk((i == 19) ? `TAIL : `PAYLOAD, 4'(i), 200 + i));
            if (credit_out) credits++;
        end
        check("stream_credits", 32'(credits), 32'd20);
        check("stream_no_ovf", 32'(ovf_err), 32'd0);

`ifdef FIFO_PROTO_CHECK_EN
        step(1, 0, 0, '0);
        step(0, 1, 0, mk(`PAYLOAD, 4'h1, 300));
        check("proto_set", 32'(proto_err), 32'd1);
        check("proto_idle_kept", 32'(in_packet), 32'd0);
        step(0, 1, 1, mk(`HEADER, 4'h3, 301));
        step(0, 1, 1, mk(`TAIL, 4'h3, 302));
        check("proto_sticky", 32'(proto_err), 32'd1);
        step(1, 0, 0, '0);
        check("proto_cleared", 32'(proto_err), 32'd0);
`endif

        // Randomized traffic; odd segments skew toward overflow, even toward draining.
        for (int seg = 0; seg < 6; seg++) begin
            step(1, 0, 0, '0);
            for (int c = 0; c < 150; c++) begin
                case ($urandom_range(0, 3))
                    0: rid = `HEADER;
                    1: rid = `TAIL;
                    default: rid = `PAYLOAD;
                endcase
                f = mk(rid, 4'($urandom_range(0, 15)), $urandom);
                if (seg % 2 == 0)
                    step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, f);
                else
                    step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, f);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
